window_stream: RTL and testbench

//  Streaming, multi-channel analysis window applied ahead of the FFT in the stereo spectrum path.

---
 rtl/spectrum_pkg.sv | 23 ++
 rtl/window_coef_rom.sv | 36 +++
 rtl/window_stream.sv | 173 +++++++++++++++++
 tb/tb_window_stream.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// Shared definitions for the stereo spectrum path.
// Window mode encodings and fixed-point window constants.
package spectrum_pkg;

    typedef enum logic [1:0] {
        WIN_RECT = 2'd0,
        WIN_HANN = 2'd1,
        WIN_HAMM = 2'd2,
        WIN_RSVD = 2'd3
    } win_mode_e;

    localparam int BW_COEF = 17;

    // round(0.54 * 2^(bw-1)) in integer arithmetic
    function automatic int a54_of(input int bw);
        return (54 * (1 << (bw - 1)) + 50) / 100;
    endfunction

    localparam int ONE  = 1 << (BW_COEF - 1);
    localparam int HALF = 1 << (BW_COEF - 2);
    localparam int A54  = a54_of(BW_COEF);

endpackage

// File: rtl/window_coef_rom.sv
// Quarter-wave cosine ROM, c[k] = round(cos(2*pi*k/N) * 2^BW-1).
// Ports: Clock, Reset, i_en (read enable), i_addr (0..N/4), o_data.
module window_coef_rom #(
    parameter int LOG2_N = 11,
    parameter int BW     = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              i_en,
    input  logic [LOG2_N-2:0] i_addr,
    output logic [BW-1:0]     o_data
);

    localparam int N = 1 << LOG2_N;
    localparam int Q = N / 4;

    logic [BW-1:0] w_rom [0:Q];

    // Table is built at elaboration; all entries are non-negative.
    for (genvar k = 0; k <= Q; k++) begin : g_rom
        localparam real ANG = 2.0 * 3.14159265358979323846
                              * real'(k) / real'(N);
        localparam int  VAL = $rtoi($cos(ANG) * real'(1 << (BW - 1))
                                    + 0.5);
        assign w_rom[k] = VAL[BW-1:0];
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            o_data <= '0;
        end else if (i_en) begin
            o_data <= w_rom[i_addr];
        end
    end

endmodule

// File: rtl/window_stream.sv
// Streaming multi-channel analysis window (rect / Hann / Hamming).
// Ports: Clock, Reset, Mode, FrameSync, InValid/InReady/InData in,
//        OutValid/OutReady/OutData/OutLast out; 4-stage pipeline.
module window_stream #(
    parameter int BW_DATA  = 16,
    parameter int BW_COEF  = 17,
    parameter int LOG2_N   = 11,
    parameter int CHANNELS = 2
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [1:0]                  Mode,
    input  logic                        FrameSync,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic [CHANNELS*BW_DATA-1:0] InData,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [CHANNELS*BW_DATA-1:0] OutData,
    output logic                        OutLast
);
    import spectrum_pkg::*;

    localparam int N  = 1 << LOG2_N;
    localparam int Q  = N / 4;
    localparam int DW = CHANNELS * BW_DATA;
    localparam int AW = LOG2_N - 1;
    localparam int CW = BW_COEF + 2;
    localparam int PW = BW_DATA + BW_COEF + 1;

    localparam logic [AW-1:0]        L_Q    = AW'(Q);
    localparam logic signed [CW-1:0] L_ONE  = CW'(1 << (BW_COEF - 1));
    localparam logic signed [CW-1:0] L_HALF = CW'(1 << (BW_COEF - 2));
    localparam logic signed [CW-1:0] L_A54  = CW'(a54_of(BW_COEF));
    localparam logic signed [PW-1:0] L_RND  = PW'(1 << (BW_COEF - 2));

    // Index / mode tracking
    logic              w_en;
    logic              w_acc;
    logic [LOG2_N-1:0] r_n;
    logic [LOG2_N-1:0] w_n;
    win_mode_e         r_mode;
    win_mode_e         w_mode;
    logic [1:0]        w_q;
    logic [LOG2_N-3:0] w_r;
    logic [AW-1:0]     w_addr;

    assign w_en    = ~OutValid | OutReady;
    assign InReady = w_en;
    assign w_acc   = InValid & w_en;
    assign w_n     = FrameSync ? '0 : r_n;
    // Mode only follows the input on the first sample of a frame.
    assign w_mode  = (w_n == '0) ? win_mode_e'(Mode) : r_mode;
    assign w_q     = w_n[LOG2_N-1 -: 2];
    assign w_r     = w_n[LOG2_N-3:0];
    assign w_addr  = w_q[0] ? L_Q - AW'(w_r) : AW'(w_r);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_n    <= '0;
            r_mode <= WIN_RECT;
        end else if (w_acc) begin
            r_n    <= w_n + 1'b1;
            r_mode <= w_mode;
        end
    end

    // Pipeline registers
    logic          r1_v, r2_v, r3_v;
    logic          r1_last, r2_last, r3_last;
    logic [1:0]    r1_q, r2_q;
    logic [AW-1:0] r1_addr;
    win_mode_e     r1_mode, r2_mode;
    logic [DW-1:0] r1_x, r2_x, r3_x;
    logic [BW_COEF-1:0] r3_coef;

    logic [BW_COEF-2:0] w_c;

    window_coef_rom #(
        .LOG2_N (LOG2_N),
        .BW     (BW_COEF - 1)
    ) u_rom (
        .Clock  (Clock),
        .Reset  (Reset),
        .i_en   (w_en),
        .i_addr (r1_addr),
        .o_data (w_c)
    );

    // S3: signed cosine, window formula, clamp to [0, 1.0]
    logic signed [BW_COEF:0] w_h;
    logic signed [BW_COEF:0] w_hs;
    logic signed [CW-1:0]    w_raw;
    logic [BW_COEF-1:0]      w_coef;

    always_comb begin
        w_h = $signed({2'b00, w_c});
        if (r2_q == 2'd1 || r2_q == 2'd2) begin
            w_h = -w_h;
        end
        w_hs = w_h - (w_h >>> 4) - (w_h >>> 6);
        case (r2_mode)
            WIN_HANN: w_raw = L_HALF - CW'(w_h);
            WIN_HAMM: w_raw = L_A54 - CW'(w_hs);
            default:  w_raw = L_ONE;
        endcase
        if (w_raw < 0) begin
            w_coef = '0;
        end else if (w_raw > L_ONE) begin
            w_coef = L_ONE[BW_COEF-1:0];
        end else begin
            w_coef = w_raw[BW_COEF-1:0];
        end
    end

    // S4: per-channel multiply with round-half-up
    logic [DW-1:0] w_y;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_mul
        logic signed [BW_DATA-1:0] w_x;
        logic signed [PW-1:0]      w_p;
        logic signed [PW-1:0]      w_s;
        logic                      w_unused;
        assign w_x = r3_x[g*BW_DATA +: BW_DATA];
        assign w_p = PW'(w_x) * PW'($signed({1'b0, r3_coef}));
        assign w_s = w_p + L_RND;
        assign w_y[g*BW_DATA +: BW_DATA] = w_s[BW_COEF-1 +: BW_DATA];
        assign w_unused = ^{w_s[PW-1 -: 2], w_s[BW_COEF-2:0]};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r1_v     <= 1'b0;
            r1_last  <= 1'b0;
            r1_q     <= '0;
            r1_addr  <= '0;
            r1_mode  <= WIN_RECT;
            r1_x     <= '0;
            r2_v     <= 1'b0;
            r2_last  <= 1'b0;
            r2_q     <= '0;
            r2_mode  <= WIN_RECT;
            r2_x     <= '0;
            r3_v     <= 1'b0;
            r3_last  <= 1'b0;
            r3_x     <= '0;
            r3_coef  <= '0;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
            OutData  <= '0;
        end else if (w_en) begin
            r1_v     <= InValid;
            r1_last  <= InValid & (&w_n);
            r1_q     <= w_q;
            r1_addr  <= w_addr;
            r1_mode  <= w_mode;
            r1_x     <= InData;
            r2_v     <= r1_v;
            r2_last  <= r1_last;
            r2_q     <= r1_q;
            r2_mode  <= r1_mode;
            r2_x     <= r1_x;
            r3_v     <= r2_v;
            r3_last  <= r2_last;
            r3_x     <= r2_x;
            r3_coef  <= w_coef;
            OutValid <= r3_v;
            OutLast  <= r3_last;
            OutData  <= w_y;
        end
    end

endmodule

// File: tb/tb_window_stream.sv
// Self-checking bench for window_stream with a real-valued window model.
// Drives directed frames plus randomized traffic and backpressure.
module tb_window_stream;

    localparam int N  = 2048;
    localparam int CH = 2;
    localparam int DW = 32;
    localparam real PI = 3.14159265358979323846;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic [1:0]    Mode = 2'd0;
    logic          FrameSync = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [DW-1:0] InData = '0;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic [DW-1:0] OutData;
    logic          OutLast;

    int nchk = 0;
    int nfail = 0;

    int            m_n = 0;
    logic [1:0]    m_mode = 2'd0;
    logic [DW-1:0] exp_d[$];
    logic [DW-1:0] got_d[$];
    bit            exp_l[$];
    bit            got_l[$];

    always #5 Clock = ~Clock;

    window_stream #(
        .BW_DATA  (16),
        .BW_COEF  (17),
        .LOG2_N   (11),
        .CHANNELS (2)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Mode      (Mode),
        .FrameSync (FrameSync),
        .InValid   (InValid),
        .InReady   (InReady),
        .InData    (InData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .OutLast   (OutLast)
    );

    // Window applied to one sample-set at index k, straight from the
    // formulas: real cosine, no quarter-wave folding.
    function automatic logic [DW-1:0] win_ref(input logic [DW-1:0] d,
                                              input int k,
                                              input logic [1:0] md);
        real v;
        longint h, hm, coef, x, y;
        logic [63:0] yv;
        logic [DW-1:0] o;
        v = $cos(2.0 * PI * real'(k) / real'(N)) * 32768.0;
        h = (v >= 0.0) ? longint'($floor(v + 0.5))
                       : -longint'($floor(0.5 - v));
        case (md)
            2'd1: coef = 32768 - h;
            2'd2: begin
                hm = h - (h >>> 4) - (h >>> 6);
                coef = 35389 - hm;
            end
            default: coef = 65536;
        endcase
        if (coef < 0) coef = 0;
        if (coef > 65536) coef = 65536;
        o = '0;
        for (int c = 0; c < CH; c++) begin
            x = longint'($signed(d[c*16 +: 16]));
            y = (x * coef + 32768) >>> 16;
            yv = y;
            o[c*16 +: 16] = yv[15:0];
        end
        return o;
    endfunction

    function automatic void model_accept(input bit fs, input logic [1:0] md,
                                         input logic [DW-1:0] d);
        int k;
        k = fs ? 0 : m_n;
        if (k == 0) m_mode = md;
        exp_d.push_back(win_ref(d, k, m_mode));
        exp_l.push_back(k == N - 1);
        m_n = (k + 1) % N;
    endfunction

    function automatic void clear_q();
        exp_d.delete();
        exp_l.delete();
        got_d.delete();
        got_l.delete();
    endfunction

    task automatic cycle(input bit v, input bit fs, input logic [1:0] md,
                         input logic [DW-1:0] d, input bit ordy,
                         output bit acc);
        @(negedge Clock);
        InValid = v;
        FrameSync = fs;
        Mode = md;
        InData = d;
        OutReady = ordy;
        #1;
        acc = InValid && InReady;
        if (OutValid && OutReady) begin
            got_d.push_back(OutData);
            got_l.push_back(OutLast);
        end
        if (acc) model_accept(fs, md, d);
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 64 && got_d.size() < exp_d.size(); i++)
            cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, a);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(negedge Clock);
        nchk++;
        if (OutValid !== 1'b0) begin
            nfail++; $display("FAIL rst_valid got %b want 0", OutValid);
        end
        nchk++;
        if (OutLast !== 1'b0) begin
            nfail++; $display("FAIL rst_last got %b want 0", OutLast);
        end
        nchk++;
        if (OutData !== '0) begin
            nfail++; $display("FAIL rst_data got %h want 0", OutData);
        end
        nchk++;
        if (InReady !== 1'b1) begin
            nfail++; $display("FAIL rst_ready got %b want 1", InReady);
        end
        Reset = 1'b0;
        m_n = 0;
        m_mode = 2'd0;
        clear_q();
    endtask

    task automatic test_hann();
        bit a;
        int nl;
        clear_q();
        for (int i = 0; i < N; i++)
            cycle(1'b1, i == 0, 2'd1, 32'h03E8_03E8, 1'b1, a);
        drain();
        nchk++;
        if (got_d.size() !== exp_d.size()) begin
            nfail++;
            $display("FAIL hann_count got %0d want %0d",
                     got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            nchk++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                nfail++;
                $display("FAIL hann_seq[%0d] got %h/%b want %h/%b", i,
                         got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        if (got_d.size() >= N) begin
            nchk++;
            if (got_d[0] !== 32'h0000_0000) begin
                nfail++; $display("FAIL hann_n0 got %h want 0", got_d[0]);
            end
            nchk++;
            if (got_d[512] !== 32'h01F4_01F4) begin
                nfail++;
                $display("FAIL hann_n512 got %h want 01f401f4", got_d[512]);
            end
            nchk++;
            if (got_d[1024] !== 32'h03E8_03E8) begin
                nfail++;
                $display("FAIL hann_n1024 got %h want 03e803e8", got_d[1024]);
            end
            nl = 0;
            foreach (got_l[i]) nl += int'(got_l[i]);
            nchk++;
            if (nl !== 1 || got_l[N-1] !== 1'b1) begin
                nfail++;
                $display("FAIL hann_last count %0d at2047 %b want 1/1",
                         nl, got_l[N-1]);
            end
        end
    endtask

    task automatic test_hamming();
        bit a;
        logic [DW-1:0] d;
        clear_q();
        for (int i = 0; i <= 1024; i++) begin
            d = (i == 0 || i == 1024) ? 32'h2710_2710 : $urandom;
            cycle(1'b1, i == 0, 2'd2, d, 1'b1, a);
        end
        drain();
        nchk++;
        if (got_d.size() !== exp_d.size()) begin
            nfail++;
            $display("FAIL hamm_count got %0d want %0d",
                     got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            nchk++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                nfail++;
                $display("FAIL hamm_seq[%0d] got %h want %h", i,
                         got_d[i], exp_d[i]);
            end
        end
        if (got_d.size() > 1024) begin
            nchk++;
            if (got_d[0] !== 32'h0317_0317) begin
                nfail++;
                $display("FAIL hamm_n0 got %h want 03170317", got_d[0]);
            end
            nchk++;
            if (got_d[1024] !== 32'h2710_2710) begin
                nfail++;
                $display("FAIL hamm_n1024 got %h want 27102710", got_d[1024]);
            end
        end
    endtask

    task automatic test_rect_extremes();
        bit a;
        logic [DW-1:0] d;
        clear_q();
        for (int i = 0; i < 32; i++) begin
            d = (i == 0) ? 32'h7FFF_8000 : (i == 1) ? 32'h8000_7FFF : $urandom;
            cycle(1'b1, i == 0 || i == 24, (i < 24) ? 2'd0 : 2'd3, d,
                  1'b1, a);
        end
        for (int i = 0; i <= 1024; i++) begin
            d = (i == 1024) ? 32'h8000_8000 : $urandom;
            cycle(1'b1, i == 0, 2'd1, d, 1'b1, a);
        end
        drain();
        nchk++;
        if (got_d.size() !== exp_d.size()) begin
            nfail++;
            $display("FAIL rect_count got %0d want %0d",
                     got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            nchk++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                nfail++;
                $display("FAIL rect_seq[%0d] got %h want %h", i,
                         got_d[i], exp_d[i]);
            end
        end
        if (got_d.size() > 32 + 1024) begin
            nchk++;
            if (got_d[0] !== 32'h7FFF_8000) begin
                nfail++;
                $display("FAIL rect_ext0 got %h want 7fff8000", got_d[0]);
            end
            nchk++;
            if (got_d[1] !== 32'h8000_7FFF) begin
                nfail++;
                $display("FAIL rect_ext1 got %h want 80007fff", got_d[1]);
            end
            nchk++;
            if (got_d[32 + 1024] !== 32'h8000_8000) begin
                nfail++;
                $display("FAIL hann_neg_full got %h want 80008000",
                         got_d[32 + 1024]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit a;
        bit st;
        int sent;
        logic [DW-1:0] d;
        logic [DW-1:0] held;
        clear_q();
        sent = 0;
        held = '0;
        for (int cyc = 0; cyc < 60 && sent < 20; cyc++) begin
            st = (cyc >= 8 && cyc < 11);
            d = $urandom;
            cycle(1'b1, sent == 0, 2'd1, d, !st, a);
            if (a) sent++;
            if (st) begin
                nchk++;
                if (InReady !== 1'b0 || OutValid !== 1'b1) begin
                    nfail++;
                    $display("FAIL stall_ready cyc %0d got rdy %b vld %b want 0/1",
                             cyc, InReady, OutValid);
                end
                if (cyc == 8) begin
                    held = OutData;
                end else begin
                    nchk++;
                    if (OutData !== held) begin
                        nfail++;
                        $display("FAIL stall_hold cyc %0d got %h want %h",
                                 cyc, OutData, held);
                    end
                end
            end
        end
        drain();
        nchk++;
        if (sent !== 20 || got_d.size() !== 20) begin
            nfail++;
            $display("FAIL b2b_count sent %0d got %0d want 20/20",
                     sent, got_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            nchk++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                nfail++;
                $display("FAIL b2b_seq[%0d] got %h want %h", i,
                         got_d[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_mode_hold();
        bit a;
        logic [DW-1:0] d;
        clear_q();
        for (int i = 0; i < N + 50; i++) begin
            d = (i == 1536 || i == N) ? 32'h03E8_03E8 : $urandom;
            cycle(1'b1, i == 0 || i == N,
                  (i < 700) ? 2'd1 : 2'd0, d, 1'b1, a);
        end
        drain();
        nchk++;
        if (got_d.size() !== exp_d.size()) begin
            nfail++;
            $display("FAIL mode_count got %0d want %0d",
                     got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            nchk++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                nfail++;
                $display("FAIL mode_seq[%0d] got %h want %h", i,
                         got_d[i], exp_d[i]);
            end
        end
        if (got_d.size() > N) begin
            nchk++;
            if (got_d[1536] !== 32'h01F4_01F4) begin
                nfail++;
                $display("FAIL mode_held got %h want 01f401f4", got_d[1536]);
            end
            nchk++;
            if (got_d[N] !== 32'h03E8_03E8) begin
                nfail++;
                $display("FAIL mode_next got %h want 03e803e8", got_d[N]);
            end
        end
    endtask

    task automatic test_resync_reset();
        bit a;
        logic [DW-1:0] d;
        clear_q();
        for (int i = 0; i < 900; i++) begin
            d = (i == 300) ? 32'h03E8_03E8 : $urandom;
            cycle(1'b1, i == 0 || i == 300, 2'd1, d, 1'b1, a);
        end
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            nchk++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                nfail++;
                $display("FAIL sync_seq[%0d] got %h want %h", i,
                         got_d[i], exp_d[i]);
            end
        end
        nchk++;
        if (got_d.size() <= 300 || got_d[300] !== 32'h0000_0000) begin
            nfail++;
            $display("FAIL sync_n0 size %0d want sample 300 = 0", got_d.size());
        end
        #2;
        Reset = 1'b1;
        InValid = 1'b0;
        #1;
        nchk++;
        if (OutValid !== 1'b0 || OutLast !== 1'b0 || OutData !== '0
            || InReady !== 1'b1) begin
            nfail++;
            $display("FAIL midrst_out got v%b l%b d%h r%b want 0/0/0/1",
                     OutValid, OutLast, OutData, InReady);
        end
        @(negedge Clock);
        Reset = 1'b0;
        m_n = 0;
        m_mode = 2'd0;
        clear_q();
        cycle(1'b1, 1'b0, 2'd1, 32'h03E8_03E8, 1'b1, a);
        cycle(1'b1, 1'b0, 2'd1, $urandom, 1'b1, a);
        drain();
        nchk++;
        if (got_d.size() !== 2 || exp_d.size() !== 2) begin
            nfail++;
            $display("FAIL postrst_count got %0d want 2", got_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            nchk++;
            if (got_d[i] !== exp_d[i]) begin
                nfail++;
                $display("FAIL postrst_seq[%0d] got %h want %h", i,
                         got_d[i], exp_d[i]);
            end
        end
        nchk++;
        if (got_d.size() < 1 || got_d[0] !== 32'h0000_0000) begin
            nfail++;
            $display("FAIL postrst_n0 size %0d want first = 0", got_d.size());
        end
    endtask

    task automatic test_random();
        bit a;
        clear_q();
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
                  2'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, 3) != 0, a);
        drain();
        nchk++;
        if (got_d.size() !== exp_d.size()) begin
            nfail++;
            $display("FAIL rand_count got %0d want %0d",
                     got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            nchk++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                nfail++;
                $display("FAIL rand_seq[%0d] got %h/%b want %h/%b", i,
                         got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_hann();
        test_hamming();
        test_rect_extremes();
        test_back_to_back();
        test_mode_hold();
        test_resync_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
